line_buf_ctrl: RTL

Controller that sequences the two 8-bit line-buffer shift registers feeding the 3x3 window stage of the stereo pixel pipeline. It accepts the camera pixel stream through a valid/ready handshake and drives the line buffers' common `shift` enable. It tracks column and row position within the frame and tells the window consumer, one pixel at a time, when the 3x3 window taps hold a complete neighbourhood. It sits between the camera capture front-end and the per-eye window/disparity logic, one instance per eye.

---
 rtl/line_buf_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/line_buf_ctrl.sv
// Line-buffer sequencer for the 3x3 window stage: accepts the raster stream, drives the shared
// shift enable and flags complete windows. Define LINE_BUF_CTRL_STATS_EN to add the drop_cnt output.
module line_buf_ctrl #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_in_valid,
  input  logic             pix_in_sof,
  output logic             pix_in_ready,
  output logic             lb_shift,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done
`ifdef LINE_BUF_CTRL_STATS_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_e;

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] LAST_FILL_ROW = ROW_W'(1);
  localparam logic [COL_W-1:0] MIN_WIN_COL   = COL_W'(2);

  state_e           state_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             win_valid_q;
  logic [COL_W-1:0] win_col_q;
  logic [ROW_W-1:0] win_row_q;
  logic             frame_done_q;

  logic in_frame;
  logic acc;
  logic shift;
  logic qualify;
  logic at_last_col;

  assign in_frame     = (state_q == FILL) || (state_q == STREAM);
  assign pix_in_ready = !win_valid_q || win_ready;
  assign acc          = pix_in_valid && pix_in_ready;
  // Shift is combinational so the buffers move in the accept cycle; reset_n gates it so nothing
  // shifts while reset is held, even with a sof pixel presented.
  assign shift        = reset_n && acc && (in_frame || pix_in_sof);
  assign lb_shift     = shift;
  assign at_last_col  = (col_q == LAST_COL);
  // Rows 0-1 only occur in FILL, so STREAM already implies row >= 2.
  assign qualify      = acc && (state_q == STREAM) && !pix_in_sof && (col_q >= MIN_WIN_COL);

  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign frame_done = frame_done_q;

  // Raster advance: wrap at the configured width rather than at the counter's natural modulus.
  always_comb begin
    col_d = col_q + COL_W'(1);
    row_d = row_q;
    if (at_last_col) begin
      col_d = '0;
      row_d = row_q + ROW_W'(1);
    end
  end

  // NOTE: every register here uses <= so all next-state terms read pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      if (qualify) begin
        win_valid_q <= 1'b1;
        win_col_q   <= col_q;
        win_row_q   <= row_q;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end

      if (acc && pix_in_sof) begin
        // A sof pixel is always (0,0): starts a frame from IDLE/DONE, aborts one in progress.
        state_q <= FILL;
        col_q   <= COL_W'(1);
        row_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            state_q <= IDLE;
          end
          FILL: begin
            if (acc) begin
              col_q <= col_d;
              row_q <= row_d;
              if (at_last_col && (row_q == LAST_FILL_ROW)) begin
                state_q <= STREAM;
              end
            end
          end
          STREAM: begin
            if (acc) begin
              if (at_last_col && (row_q == LAST_ROW)) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
                col_q        <= '0;
                row_q        <= '0;
              end else begin
                col_q <= col_d;
                row_q <= row_d;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef LINE_BUF_CTRL_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (acc && !shift && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
